// File: rtl/io_uart_arbiter.sv
// io_uart_arbiter: two byte-write ports (A, B), each with its own small FIFO,
// merged onto a single valid/ready UART transmit interface by a round-robin
// arbiter. Bytes from one port leave in write order; writes to a full FIFO
// are dropped and flagged on a sticky overflow bit.
// DEPTH must be a power of two in 2..16 so pointers wrap naturally.

// Per-port byte FIFO: registered count, wrapping pointers, sticky overflow.
module io_uart_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Full is judged on the registered count only, so a pop on the same edge
  // never makes room for a push, and busy has no path from the write strobe.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr_en = i_push && !w_full;
  assign w_rd_en = i_pop && !w_empty;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer, occupancy and sticky-overflow bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end
endmodule

// Top level: two FIFOs, IDLE/SEND arbiter FSM and the UART output register.
module io_uart_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_busy,
  output logic       a_ovf,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_busy,
  output logic       b_ovf,
  output logic       uart_valid,
  output logic [7:0] uart_data,
  input  logic       uart_ready,
  output logic       uart_src
);
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_uart_valid;
  logic [7:0] r_uart_data;
  logic       r_uart_src;
  logic       r_last_b;   // 1 = port B received the most recent grant

  logic [7:0] w_a_head;
  logic [7:0] w_b_head;
  logic       w_a_empty;
  logic       w_b_empty;
  logic       w_pop_a;
  logic       w_pop_b;
  logic       w_load;
  logic       w_release;
  logic       w_sel_b;

  io_uart_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (a_valid),
    .i_data  (a_data),
    .i_pop   (w_pop_a),
    .o_head  (w_a_head),
    .o_empty (w_a_empty),
    .o_full  (a_busy),
    .o_ovf   (a_ovf)
  );

  io_uart_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (b_valid),
    .i_data  (b_data),
    .i_pop   (w_pop_b),
    .o_head  (w_b_head),
    .o_empty (w_b_empty),
    .o_full  (b_busy),
    .o_ovf   (b_ovf)
  );

  // Arbiter state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant selection and pop/load strobes.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_a     = 1'b0;
    w_pop_b     = 1'b0;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_sel_b     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_a_empty || !w_b_empty) begin
          w_load = 1'b1;
          if (w_a_empty) begin
            w_sel_b = 1'b1;
          end else if (w_b_empty) begin
            w_sel_b = 1'b0;
          end else begin
            // Both waiting: grant the port that did not win last time.
            w_sel_b = !r_last_b;
          end
          w_pop_a     = !w_sel_b;
          w_pop_b     = w_sel_b;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (uart_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output register and last-grant tracking; the offer holds until accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_uart_valid <= 1'b0;
      r_uart_data  <= 8'h00;
      r_uart_src   <= 1'b0;
      r_last_b     <= 1'b1;
    end else if (w_load) begin
      r_uart_valid <= 1'b1;
      r_uart_data  <= w_sel_b ? w_b_head : w_a_head;
      r_uart_src   <= w_sel_b;
      r_last_b     <= w_sel_b;
    end else if (w_release) begin
      r_uart_valid <= 1'b0;
    end
  end

  assign uart_valid = r_uart_valid;
  assign uart_data  = r_uart_data;
  assign uart_src   = r_uart_src;
endmodule

// File: tb/tb_io_uart_arbiter.sv
// Self-checking bench for io_uart_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run compared cycle by
// cycle against a queue-based transaction model plus a per-port scoreboard.
module tb_io_uart_arbiter;
  localparam int DEPTH = 4;

  logic       clk;
  logic       resetn;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_busy;
  logic       a_ovf;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_busy;
  logic       b_ovf;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_ready;
  logic       uart_src;

  int n_checks = 0;
  int n_err    = 0;

  io_uart_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_busy     (a_busy),
    .a_ovf      (a_ovf),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_busy     (b_busy),
    .b_ovf      (b_ovf),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .uart_src   (uart_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_data = 8'h00;
    uart_ready = 1'b0;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       eab;
    logic       eao;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  // ---------------- transaction model ----------------
  logic [7:0] mq_a[$];
  logic [7:0] mq_b[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_src;
  logic       m_last_b;
  logic       m_ovf_a;
  logic       m_ovf_b;
  logic [7:0] acc_a[$];   // bytes the model says were accepted, per port
  logic [7:0] acc_b[$];
  logic [7:0] emit_a[$];  // bytes the DUT actually handed to the UART
  logic [7:0] emit_b[$];
  logic [7:0] got[$];

  task automatic model_reset();
    mq_a.delete(); mq_b.delete();
    acc_a.delete(); acc_b.delete();
    emit_a.delete(); emit_b.delete();
    m_valid = 1'b0; m_data = 8'h00; m_src = 1'b0;
    m_last_b = 1'b1; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
  endtask

  // One clock edge of the arbiter behaviour, from the rules: capacity is
  // judged before the edge; an empty output slot takes one queued byte,
  // round-robin on ties; an occupied slot frees only when accepted.
  task automatic model_step(input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd,
                            input logic rdy);
    bit room_a;
    bit room_b;
    bit pick_b;
    room_a = (mq_a.size() < DEPTH);
    room_b = (mq_b.size() < DEPTH);
    if (m_valid) begin
      if (rdy) m_valid = 1'b0;
    end else if (mq_a.size() > 0 || mq_b.size() > 0) begin
      if (mq_a.size() == 0)      pick_b = 1'b1;
      else if (mq_b.size() == 0) pick_b = 1'b0;
      else                       pick_b = !m_last_b;
      m_data   = pick_b ? mq_b.pop_front() : mq_a.pop_front();
      m_src    = pick_b;
      m_last_b = pick_b;
      m_valid  = 1'b1;
    end
    if (av) begin
      if (room_a) begin mq_a.push_back(ad); acc_a.push_back(ad); end
      else m_ovf_a = 1'b1;
    end
    if (bv) begin
      if (room_b) begin mq_b.push_back(bd); acc_b.push_back(bd); end
      else m_ovf_b = 1'b1;
    end
  endtask

  logic [31:0] exp_vec;
  logic [31:0] act_vec;
  logic        r_av, r_bv, r_rdy;
  logic [7:0]  r_ad, r_bd;

  initial begin
    idle_inputs();
    resetn = 1'b0;
    #3;
    // Outputs while reset is held, before any clock edge.
    check("rst valid", uart_valid, 1'b0);
    check("rst data",  uart_data,  8'h00);
    check("rst src",   uart_src,   1'b0);
    check("rst busy",  {a_busy, b_busy}, 2'b00);
    check("rst ovf",   {a_ovf, b_ovf},   2'b00);
    @(posedge clk);
    #2;
    resetn = 1'b1;

    // rst av ad bv bd rdy | ev ed es eab eao
    tbl[0]  = '{1'b1, 1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h43, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h5a, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5a, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5a, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].rst) do_reset();
      a_valid = tbl[i].av; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_data = tbl[i].bd;
      uart_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i), uart_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d data", i), uart_data, tbl[i].ed);
        check($sformatf("vec%0d src", i),  uart_src,  tbl[i].es);
      end
      check($sformatf("vec%0d a_busy", i), a_busy, tbl[i].eab);
      check($sformatf("vec%0d a_ovf", i),  a_ovf,  tbl[i].eao);
    end

    // ---- fill A to full with the transmitter stalled, then overflow ----
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      a_valid = 1'b1; a_data = 8'(i);
      tick();
    end
    check("fill busy",  a_busy, 1'b1);
    check("fill ovf",   a_ovf,  1'b0);
    check("fill valid", uart_valid, 1'b1);
    check("fill data",  uart_data,  8'h01);
    a_data = 8'h06;
    tick();
    check("ovf set",    a_ovf,  1'b1);
    check("ovf busy",   a_busy, 1'b1);
    a_valid = 1'b0;
    uart_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (uart_valid && uart_ready) got.push_back(uart_data);
      tick();
    end
    check("fill drain count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      check($sformatf("fill drain %0d", i), got[i], 8'(i + 1));

    // ---- full FIFO: pop and push on the same edge drops the push ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_data = 8'h10 + 8'(i);
      tick();
    end
    a_valid = 1'b0;
    uart_ready = 1'b1;
    tick();
    check("pp release valid", uart_valid, 1'b0);
    check("pp still busy",    a_busy,     1'b1);
    uart_ready = 1'b0;
    a_valid = 1'b1; a_data = 8'h15;
    tick();
    a_valid = 1'b0;
    check("pp ovf",   a_ovf,     1'b1);
    check("pp busy",  a_busy,    1'b0);
    check("pp valid", uart_valid, 1'b1);
    check("pp data",  uart_data,  8'h11);
    uart_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (uart_valid && uart_ready) got.push_back(uart_data);
      tick();
    end
    check("pp drain count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("pp drain %0d", i), got[i], 8'h11 + 8'(i));

    // ---- asynchronous reset in the middle of SEND ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 4); a_data = 8'h20 + 8'(i);
      b_valid = 1'b1;    b_data = 8'h30 + 8'(i);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("mid valid", uart_valid, 1'b1);
    check("mid b_ovf", b_ovf, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("async valid", uart_valid, 1'b0);
    check("async busy",  {a_busy, b_busy}, 2'b00);
    check("async ovf",   {a_ovf, b_ovf},   2'b00);
    check("async data",  uart_data, 8'h00);
    #1;
    resetn = 1'b1;
    a_valid = 1'b1; a_data = 8'h55; uart_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    check("post-rst lat", uart_valid, 1'b0);
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        check("post-rst valid", uart_valid, 1'b0);
      end
      tick();
      if (c == 0) begin
        check("post-rst first", uart_valid, 1'b1);
        check("post-rst src",   uart_src,   1'b0);
      end
      if (uart_valid && uart_ready) got.push_back(uart_data);
    end
    check("post-rst count", got.size(), 1);
    if (got.size() > 0) check("post-rst byte", got[0], 8'h55);

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 10000 + 40; c++) begin
      if (c < 10000) begin
        r_av  = ($urandom_range(0, 99) < 45);
        r_bv  = ($urandom_range(0, 99) < 45);
        r_rdy = ($urandom_range(0, 99) < 55);
      end else begin
        r_av = 1'b0; r_bv = 1'b0; r_rdy = 1'b1;
      end
      r_ad = 8'($urandom);
      r_bd = 8'($urandom);
      a_valid = r_av; a_data = r_ad;
      b_valid = r_bv; b_data = r_bd;
      uart_ready = r_rdy;
      if (uart_valid && uart_ready) begin
        if (uart_src) emit_b.push_back(uart_data);
        else          emit_a.push_back(uart_data);
      end
      model_step(r_av, r_ad, r_bv, r_bd, r_rdy);
      tick();
      exp_vec = {17'd0, m_valid, (m_valid ? m_data : 8'h00), (m_valid ? m_src : 1'b0),
                 (mq_a.size() == DEPTH), m_ovf_a, (mq_b.size() == DEPTH), m_ovf_b};
      act_vec = {17'd0, uart_valid, (m_valid ? uart_data : 8'h00), (m_valid ? uart_src : 1'b0),
                 a_busy, a_ovf, b_busy, b_ovf};
      check($sformatf("rand cyc%0d", c), act_vec, exp_vec);
      if (n_err > 50) break;
    end
    check("sb a count", emit_a.size(), acc_a.size());
    check("sb b count", emit_b.size(), acc_b.size());
    for (int i = 0; i < emit_a.size() && i < acc_a.size(); i++)
      check($sformatf("sb a %0d", i), emit_a[i], acc_a[i]);
    for (int i = 0; i < emit_b.size() && i < acc_b.size(); i++)
      check($sformatf("sb b %0d", i), emit_b[i], acc_b[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/io_uart_arbiter.md
IO_UART_ARBITER -- requirements
Module: io_uart_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4, per-port FIFO depth in bytes; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  port A byte-write strobe, one cycle per byte.
REQ-005 a_data  input  8  port A byte, sampled when a_valid=1.
REQ-006 a_busy  output  1  port A FIFO full.
REQ-007 a_ovf  output  1  sticky: port A write dropped.
REQ-008 b_valid  input  1  port B byte-write strobe.
REQ-009 b_data  input  8  port B byte.
REQ-010 b_busy  output  1  port B FIFO full.
REQ-011 b_ovf  output  1  sticky: port B write dropped.
REQ-012 uart_valid  output  1  byte offered to UART transmitter.
REQ-013 uart_data  output  8  offered byte; stable while uart_valid=1.
REQ-014 uart_ready  input  1  transmitter can accept; transfer occurs on an edge where uart_valid=1 and uart_ready=1.
REQ-015 uart_src  output  1  source of offered byte: 0=A, 1=B.

Function
REQ-016 Each port SHALL own an independent FIFO of DEPTH bytes with a count 0..DEPTH and pointers that wrap modulo DEPTH.
REQ-017 Push: on an edge with x_valid=1, the byte SHALL be written iff the registered count is below DEPTH; a pop on the same edge SHALL NOT free space for that push.
REQ-018 A push attempted while full SHALL be discarded, SHALL leave the FIFO unchanged, and SHALL set x_ovf; x_ovf SHALL clear only on reset.
REQ-019 x_busy SHALL equal (count==DEPTH), registered-derived, with no combinational path from x_valid.
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged and preserve byte order.
REQ-021 The arbiter FSM SHALL have two states: IDLE and SEND.
REQ-022 IDLE: if either FIFO is non-empty, the FSM SHALL pop one head byte into uart_data, set uart_src, assert uart_valid, and go to SEND on the same edge; otherwise it SHALL stay in IDLE.
REQ-023 Selection: if one FIFO is non-empty, that port SHALL be chosen; if both are non-empty, the port not granted last SHALL be chosen (round-robin); the last-grant register SHALL update on each pop.
REQ-024 SEND: uart_valid, uart_data and uart_src SHALL hold until an edge with uart_ready=1; on that edge uart_valid SHALL deassert and the FSM SHALL return to IDLE.
REQ-025 Latency: a byte pushed into an empty FIFO on edge t, with the FSM in IDLE, SHALL appear with uart_valid=1 after edge t+1.
REQ-026 Throughput: at most one byte SHALL be sent per two edges (SEND→IDLE→SEND).
REQ-027 Bytes from the same port SHALL be emitted in write order; bytes SHALL never be duplicated or lost except by overflow discard.
REQ-028 Pushes to both ports on the same edge SHALL both be accepted, subject only to their own full conditions.

Reset
REQ-029 While resetn=0, asynchronously: both FIFO counts and pointers =0; FSM=IDLE; uart_valid=0; uart_data=0; uart_src=0; a_busy=b_busy=0; a_ovf=b_ovf=0; last-grant=B, so A wins the first tie.
REQ-030 Reset asserted during SEND SHALL drop the offered byte and all queued bytes; no uart transfer SHALL be counted on that edge.
REQ-031 After resetn rises, the first push SHALL be accepted on the next edge.

Verification
REQ-032 A writes 0x48 with uart_ready=1 held → uart_valid=1, uart_data=0x48, uart_src=0 after the second edge; deasserts one edge later.
REQ-033 Same edge: A writes 0x41 and B writes 0x42, ready=1 → UART sequence is 0x41(src0), 0x42(src1); then A 0x43 and B 0x44 together → 0x44 before 0x43 is not allowed; order is 0x43, 0x44 because last grant was B.
REQ-034 uart_ready=0, A writes 5 bytes 0x01..0x05 with DEPTH=4 → first byte moves to the output register; 0x02..0x05 fill the FIFO; a_busy=1; a_ovf=0; a 6th write 0x06 → discarded, a_ovf=1; after ready=1 the output is 0x01..0x05.
REQ-035 FIFO full with a pop and push on the same edge → push is dropped and ovf is set; the count goes DEPTH→DEPTH-1.
REQ-036 resetn pulsed low mid-SEND with 3 bytes queued → uart_valid=0 immediately, with no clk edge needed; all counts =0; ovf=0; the next single write emits normally.
REQ-037 Random A/B writes with random uart_ready over 10k cycles → scoreboard: per-port order is preserved, with no loss except flagged overflow.
